// File: rtl/tiny1_mmio_pkg.sv
// tiny1_mmio_pkg: shared constants and types for the tiny1 MMIO UART hub.
//   - per-channel register offsets within a channel block
//   - global register addresses (IRQ_PEND, IRQ_DONE)
//   - STATUS bit positions
//   - IRQ handshake FSM state type
package tiny1_mmio_pkg;

  localparam int unsigned OFF_STATUS = 0;
  localparam int unsigned OFF_RXDATA = 1;
  localparam int unsigned OFF_TXDATA = 2;
  localparam int unsigned OFF_IRQEN  = 3;
  localparam int unsigned OFF_CLR    = 4;

  localparam int unsigned ADDR_IRQ_PEND = 513;
  localparam int unsigned ADDR_IRQ_DONE = 514;

  localparam int ST_RXNE   = 0;
  localparam int ST_TXNF   = 1;
  localparam int ST_RXOVF  = 2;
  localparam int ST_TXDROP = 3;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_RAISED  = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/tiny1_byte_fifo.sv
// tiny1_byte_fifo: byte FIFO of depth 2**AW.
//   clk, rst   : clock, async active-low reset (empties the FIFO)
//   push, din  : write request and byte
//   pop        : read request (ignored when empty)
//   full/empty : occupancy flags
//   count      : occupancy, AW+1 bits
//   head       : byte at the read pointer, 0 when empty
//   drop       : push refused this cycle (full and no pop to make room)
module tiny1_byte_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic [7:0]  head,
  output logic        drop
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full  = cnt_q[AW];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = empty ? 8'h00 : mem_q[rp_q];

  // a pop in the same cycle frees the slot the push needs
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage needs no reset; head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end

endmodule

// File: rtl/tiny1_mmio_uart_hub.sv
// tiny1_mmio_uart_hub: MMIO hub serving NCH byte UART channels.
//   clk, rst          : clock, async active-low reset
//   sel, addr, wdata  : mmap select, word address, write data
//   wr, rd            : write/read strobes (qualified by sel)
//   rdata             : read data, registered, valid the cycle after rd
//   uart_din/valid    : per-channel RX byte and push strobe
//   uart_out/valid    : per-channel TX FIFO head and non-empty
//   uart_out_ready    : per-channel TX sink accept
//   irq, irqack       : interrupt request / acknowledge pulse
//   halt              : 1-cycle pulse after a write to HALT_ADDR
module tiny1_mmio_uart_hub
  import tiny1_mmio_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int FIFO_AW   = 4,
  parameter int CH_STRIDE = 8,
  parameter int HALT_ADDR = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic [10:0]        addr,
  input  logic [15:0]        wdata,
  input  logic               wr,
  input  logic               rd,
  output logic [15:0]        rdata,
  input  logic [8*NCH-1:0]   uart_din,
  input  logic [NCH-1:0]     uart_valid,
  output logic [8*NCH-1:0]   uart_out,
  output logic [NCH-1:0]     uart_out_valid,
  input  logic [NCH-1:0]     uart_out_ready,
  output logic               irq,
  input  logic               irqack,
  output logic               halt
);

  logic        rd_act, wr_act, done_wr;
  logic [15:0] ch_rdata [NCH];
  logic [NCH-1:0] pend;
  logic [15:0] rdata_d, rdata_q;
  logic        halt_q, irq_d, irq_q;
  irq_state_e  state_d, state_q;

  assign rd_act  = sel & rd;
  assign wr_act  = sel & wr;
  assign done_wr = wr_act & (addr == 11'(ADDR_IRQ_DONE));

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [11:0] BASE = 12'(c * CH_STRIDE);
    localparam logic [11:0] LIM  = 12'((c + 1) * CH_STRIDE);

    logic        blk;
    logic [11:0] off;
    logic        hit_st, hit_rx, hit_tx, hit_en, hit_clr;
    logic        rx_full, rx_empty, rx_drop, tx_full, tx_empty, tx_drop;
    logic [FIFO_AW:0] rx_cnt, tx_cnt;
    logic [7:0]  rx_head, tx_head, rx_sat;
    logic [15:0] cnt16;
    logic        rx_ovf_q, tx_drop_q;
    logic [1:0]  irqen_q;

    assign blk     = ({1'b0, addr} >= BASE) && ({1'b0, addr} < LIM);
    assign off     = {1'b0, addr} - BASE;
    assign hit_st  = blk && (off == 12'(OFF_STATUS));
    assign hit_rx  = blk && (off == 12'(OFF_RXDATA));
    assign hit_tx  = blk && (off == 12'(OFF_TXDATA));
    assign hit_en  = blk && (off == 12'(OFF_IRQEN));
    assign hit_clr = blk && (off == 12'(OFF_CLR));

    tiny1_byte_fifo #(.AW(FIFO_AW)) u_rx (
      .clk   (clk),
      .rst   (rst),
      .push  (uart_valid[c]),
      .pop   (rd_act & hit_rx),
      .din   (uart_din[8*c +: 8]),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_cnt),
      .head  (rx_head),
      .drop  (rx_drop)
    );

    tiny1_byte_fifo #(.AW(FIFO_AW)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_act & hit_tx),
      .pop   (~tx_empty & uart_out_ready[c]),
      .din   (wdata[7:0]),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_cnt),
      .head  (tx_head),
      .drop  (tx_drop)
    );

    assign uart_out[8*c +: 8] = tx_head;
    assign uart_out_valid[c]  = ~tx_empty;

    // rx_count field is 8 bits wide; deeper FIFOs saturate at 255
    assign cnt16  = 16'(rx_cnt);
    assign rx_sat = (cnt16 > 16'd255) ? 8'hFF : cnt16[7:0];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rx_ovf_q  <= 1'b0;
        tx_drop_q <= 1'b0;
        irqen_q   <= 2'b00;
      end else begin
        if (wr_act && hit_en) irqen_q <= wdata[1:0];
        // a fresh drop wins over a same-cycle clear so no event is lost
        if (rx_drop)                              rx_ovf_q <= 1'b1;
        else if (wr_act && hit_clr && wdata[ST_RXOVF]) rx_ovf_q <= 1'b0;
        if (tx_drop)                                tx_drop_q <= 1'b1;
        else if (wr_act && hit_clr && wdata[ST_TXDROP]) tx_drop_q <= 1'b0;
      end
    end

    assign pend[c] = (irqen_q[0] & ~rx_empty) | (irqen_q[1] & tx_empty);

    always_comb begin
      ch_rdata[c] = 16'h0000;
      if (hit_st) begin
        ch_rdata[c][15:8]      = rx_sat;
        ch_rdata[c][ST_RXNE]   = ~rx_empty;
        ch_rdata[c][ST_TXNF]   = ~tx_full;
        ch_rdata[c][ST_RXOVF]  = rx_ovf_q;
        ch_rdata[c][ST_TXDROP] = tx_drop_q;
      end else if (hit_rx) begin
        ch_rdata[c] = {8'h00, rx_head};
      end else if (hit_en) begin
        ch_rdata[c] = {14'h0000, irqen_q};
      end
    end
  end

  // channel blocks are disjoint, so OR-ing them is a plain mux
  always_comb begin
    rdata_d = 16'h0000;
    for (int c = 0; c < NCH; c++) rdata_d = rdata_d | ch_rdata[c];
    if (addr == 11'(ADDR_IRQ_PEND)) rdata_d = 16'(pend);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IRQ_IDLE:    if (|pend)   state_d = IRQ_RAISED;
      IRQ_RAISED:  if (irqack)  state_d = IRQ_SERVICE;
      IRQ_SERVICE: if (done_wr) state_d = IRQ_IDLE;
      default:                  state_d = IRQ_IDLE;
    endcase
    irq_d = (state_d == IRQ_RAISED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IRQ_IDLE;
      irq_q   <= 1'b0;
      halt_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      halt_q  <= wr_act && (addr == 11'(HALT_ADDR));
      if (rd_act) rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;
  assign halt  = halt_q;

endmodule

// File: tb/tb_tiny1_mmio_uart_hub.sv
module tb_tiny1_mmio_uart_hub;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic rst, sel, wr, rd, irqack, irq, halt;
  logic [10:0] addr;
  logic [15:0] wdata, rdata;
  logic [8*NCH-1:0] uart_din, uart_out;
  logic [NCH-1:0] uart_valid, uart_out_valid, uart_out_ready;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];

  tiny1_mmio_uart_hub #(.NCH(NCH), .FIFO_AW(4), .CH_STRIDE(8), .HALT_ADDR(512)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wdata(wdata), .wr(wr), .rd(rd),
    .rdata(rdata), .uart_din(uart_din), .uart_valid(uart_valid), .uart_out(uart_out),
    .uart_out_valid(uart_out_valid), .uart_out_ready(uart_out_ready),
    .irq(irq), .irqack(irqack), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // read scoreboard: a read seen at an edge is compared 1 time unit later
  always @(posedge clk) begin
    bit seen;
    seen = sel & rd & rst;
    #1;
    if (seen) begin
      if (exp_q.size() == 0) chk("rd_no_expect", 1, 0);
      else chk("rdata", rdata, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input int a, input logic [15:0] e);
    sel = 1'b1; rd = 1'b1; addr = 11'(a);
    exp_q.push_back(e);
    step();
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_wr(input int a, input logic [15:0] d);
    sel = 1'b1; wr = 1'b1; addr = 11'(a); wdata = d;
    step();
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic rx_push(input int ch, input logic [7:0] b);
    uart_valid[ch] = 1'b1;
    uart_din[8*ch +: 8] = b;
    step();
    uart_valid = '0;
  endtask

  task automatic ack();
    irqack = 1'b1;
    step();
    irqack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; irqack = 1'b0;
    addr = '0; wdata = '0; uart_din = '0; uart_valid = '0; uart_out_ready = '0;
    #1;
    chk("rst_irq", irq, 0);
    chk("rst_halt", halt, 0);
    chk("rst_uov", uart_out_valid, 0);
    chk("rst_rdata", rdata, 0);
    step(); step();
    rst = 1'b1;
    step();

    // RX flow on ch0
    rx_push(0, 8'h41);
    rx_push(0, 8'h42);
    bus_rd(0, 16'h0203);
    bus_rd(1, 16'h0041);
    bus_rd(1, 16'h0042);
    bus_rd(1, 16'h0000);
    bus_rd(0, 16'h0002);

    // overflow on ch1: 17th byte (0x20) is dropped
    for (int i = 0; i < 17; i++) rx_push(1, 8'(16 + i));
    bus_rd(8, 16'h1007);
    bus_wr(12, 16'h0004);
    bus_rd(8, 16'h1003);
    uart_valid[1] = 1'b1; uart_din[15:8] = 8'hAA;
    bus_rd(9, 16'h0010);
    uart_valid = '0;
    bus_rd(8, 16'h1003);
    for (int i = 1; i < 16; i++) bus_rd(9, 16'(16 + i));
    bus_rd(9, 16'h00AA);
    bus_rd(8, 16'h0002);

    // TX backpressure on ch0
    bus_wr(2, 16'h0055);
    bus_wr(2, 16'h0066);
    chk("tx_valid", uart_out_valid, 2'b01);
    chk("tx_head0", uart_out[7:0], 8'h55);
    step(); step();
    chk("tx_hold", uart_out[7:0], 8'h55);
    uart_out_ready[0] = 1'b1;
    step();
    chk("tx_head1", uart_out[7:0], 8'h66);
    chk("tx_valid1", uart_out_valid[0], 1);
    step();
    chk("tx_drained", uart_out_valid[0], 0);
    uart_out_ready = '0;

    // TX full: 17th write dropped, status shows drop and not tx_notfull
    for (int i = 0; i < 17; i++) bus_wr(2, 16'(i));
    bus_rd(0, 16'h0008);
    uart_out_ready[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_seq", uart_out[7:0], 8'(i));
      step();
    end
    chk("tx_empty", uart_out_valid[0], 0);
    uart_out_ready = '0;
    bus_wr(4, 16'h0008);
    bus_rd(0, 16'h0002);

    // IRQ handshake on ch1 rx
    bus_wr(11, 16'h0001);
    bus_rd(11, 16'h0001);
    chk("irq_idle", irq, 0);
    rx_push(1, 8'h77);
    chk("irq_lat", irq, 0);
    step();
    chk("irq_raise", irq, 1);
    bus_rd(513, 16'h0002);
    ack();
    chk("irq_ack", irq, 0);
    step(); step();
    chk("irq_svc", irq, 0);
    bus_wr(514, 16'h0000);
    chk("irq_done", irq, 0);
    step();
    chk("irq_reraise", irq, 1);
    bus_rd(9, 16'h0077);
    chk("irq_hold", irq, 1);
    bus_rd(513, 16'h0000);
    ack();
    bus_wr(514, 16'h0000);
    step(); step();
    chk("irq_quiet", irq, 0);
    bus_wr(11, 16'h0000);

    // tx-empty interrupt on ch0
    bus_wr(3, 16'h0002);
    step();
    chk("irq_txe", irq, 1);
    bus_rd(513, 16'h0001);
    bus_wr(3, 16'h0000);
    ack();
    bus_wr(514, 16'h0000);
    step();
    chk("irq_txe_off", irq, 0);

    // halt, sel=0 and unmapped accesses
    bus_wr(512, 16'h0001);
    chk("halt_hi", halt, 1);
    step();
    chk("halt_lo", halt, 0);
    wr = 1'b1; addr = 11'd512;
    step();
    chk("halt_nosel", halt, 0);
    addr = 11'd3; wdata = 16'h0003;
    step();
    wr = 1'b0;
    bus_rd(3, 16'h0000);
    bus_rd(700, 16'h0000);
    bus_rd(512, 16'h0000);
    rx_push(0, 8'h99);
    rd = 1'b1; addr = 11'd1;
    step();
    rd = 1'b0;
    bus_rd(0, 16'h0103);
    bus_rd(1, 16'h0099);

    // async reset mid-activity
    bus_wr(11, 16'h0001);
    rx_push(1, 8'h5A);
    step();
    chk("pre_rst_irq", irq, 1);
    bus_wr(2, 16'h0033);
    chk("pre_rst_uov", uart_out_valid[0], 1);
    sel = 1'b1; wr = 1'b1; addr = 11'd512; uart_valid[1] = 1'b1;
    step();
    sel = 1'b0; wr = 1'b0;
    chk("pre_rst_halt", halt, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_irq", irq, 0);
    chk("arst_uov", uart_out_valid, 0);
    chk("arst_halt", halt, 0);
    uart_valid = '0;
    step();
    rst = 1'b1;
    step();
    bus_rd(0, 16'h0002);
    bus_rd(8, 16'h0002);
    step();
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
